// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, constants and bit-timing helpers for the UART link
package uart_pkg;
   localparam int DATA_W = 8;
   localparam logic IDLE_LEVEL = 1'b1;
   typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} uart_state_t;
   function automatic int calc_b_cnt(input int clk_f, input int uart_b);
      return clk_f / uart_b;
   endfunction
   function automatic int calc_cnt_w(input int b_cnt);
      return (b_cnt > 1) ? $clog2(b_cnt) : 1;
   endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: start/ready byte handshake between a local producer and the transmitter
interface uart_tx_if;
   import uart_pkg::*;
   logic TX_START;
   logic [DATA_W-1:0] TX_DATA;
   logic TX_READY;
   modport master (output TX_START, output TX_DATA, input TX_READY);
   modport slave (input TX_START, input TX_DATA, output TX_READY);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, one-cycle tick on the last count of each period
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int B_CNT = 434
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clr,
   output logic tick
);
   localparam int CNT_W = calc_cnt_w(B_CNT);
   logic [CNT_W-1:0] cnt;
   assign tick = (cnt == CNT_W'(B_CNT - 1));
   // free-running count that wraps on the tick and holds at zero while cleared
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) cnt <= '0;
      else cnt <= (clr || tick) ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 serializer with a one-entry holding buffer for gapless back-to-back frames
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_F = 50000000,
   parameter int UART_B = 115200,
   parameter int STOP_BITS = 1
) (
   input  logic      CLK,
   input  logic      RST_N,
   input  logic      TX_EN,
   uart_tx_if.slave  tx_bus,
   output logic      TX_OUT,
   output logic      BUSY,
   output logic      DONE
);
   localparam int B_CNT = calc_b_cnt(CLK_F, UART_B);
   uart_state_t state;
   logic [DATA_W-1:0] shifter, buf_data;
   logic [2:0] bit_idx;
   logic stop_idx, buf_full, tick, accept, frame_end;
   assign tx_bus.TX_READY = TX_EN && !buf_full;
   assign accept = tx_bus.TX_START && tx_bus.TX_READY;
   assign frame_end = (state == STOP_BIT) && tick && (stop_idx == 1'(STOP_BITS - 1));
   assign BUSY = (state != IDLE) || buf_full;
   uart_baud_cnt #(.B_CNT(B_CNT)) u_baud (
      .CLK(CLK),
      .RST_N(RST_N),
      .clr(!TX_EN || state == IDLE),
      .tick(tick)
   );
   // frame sequencer; an accept that cannot go straight into the shifter lands in the buffer
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         shifter <= '0;
         buf_data <= '0;
         bit_idx <= '0;
         stop_idx <= 1'b0;
         buf_full <= 1'b0;
         TX_OUT <= IDLE_LEVEL;
         DONE <= 1'b0;
      end else if (!TX_EN) begin
         state <= IDLE;
         bit_idx <= '0;
         stop_idx <= 1'b0;
         buf_full <= 1'b0;
         TX_OUT <= IDLE_LEVEL;
         DONE <= 1'b0;
      end else begin
         DONE <= frame_end;
         if (accept && state != IDLE && !frame_end) begin
            buf_data <= tx_bus.TX_DATA;
            buf_full <= 1'b1;
         end
         case (state)
            IDLE: if (accept) begin
               shifter <= tx_bus.TX_DATA;
               state <= START_BIT;
               TX_OUT <= 1'b0;
            end
            START_BIT: if (tick) begin
               state <= DATA_BITS;
               bit_idx <= '0;
               TX_OUT <= shifter[0];
            end
            DATA_BITS: if (tick) begin
               shifter <= shifter >> 1;
               bit_idx <= bit_idx + 3'd1;
               TX_OUT <= shifter[1];
               if (bit_idx == 3'd7) begin
                  state <= STOP_BIT;
                  stop_idx <= 1'b0;
                  TX_OUT <= IDLE_LEVEL;
               end
            end
            STOP_BIT: if (frame_end) begin
               if (buf_full || accept) begin
                  shifter <= buf_full ? buf_data : tx_bus.TX_DATA;
                  buf_full <= 1'b0;
                  state <= START_BIT;
                  TX_OUT <= 1'b0;
               end else state <= IDLE;
            end else if (tick) stop_idx <= 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
